// File: rtl/clk_freq_div_pkg.sv
// Shared types and constants for the clock-frequency divider.
// Status slave exists only when CLK_FREQ_DIV_STATUS_EN is defined.
package clk_freq_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MIN_DIV = 2;

    localparam logic [1:0] ADDR_ACTIVE  = 2'd0;
    localparam logic [1:0] ADDR_PERIODS = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;

endpackage

// File: rtl/clk_freq_div_status.sv
// Avalon-MM read-only status slave with a free-running period counter.
// Instantiated by clk_freq_div_gen only under CLK_FREQ_DIV_STATUS_EN.
module clk_freq_div_status
    import clk_freq_div_pkg::*;
#(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic [DIV_W-1:0] active_div,
    input  logic             run,
    input  logic             clk_out,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    output logic [31:0]      readdata
);

    logic [31:0] periods;
    logic [31:0] active_32;

    assign active_32 = 32'(active_div);

    // Read data is registered: one-cycle latency, zero whenever not reading.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            periods  <= '0;
            readdata <= '0;
        end else begin
            if (tick) begin
                periods <= periods + 32'd1;
            end
            if (chipselect && read) begin
                case (address)
                    ADDR_ACTIVE:  readdata <= active_32;
                    ADDR_PERIODS: readdata <= periods;
                    ADDR_STATUS:  readdata <= {30'b0, run, clk_out};
                    default:      readdata <= '0;
                endcase
            end else begin
                readdata <= '0;
            end
        end
    end

endmodule

// File: rtl/clk_freq_div_gen.sv
// Divided clock-enable generator driven by a PIO divisor word; divisor changes apply
// only at period boundaries. Define CLK_FREQ_DIV_STATUS_EN for the Avalon status slave.
module clk_freq_div_gen
    import clk_freq_div_pkg::*;
#(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div_value,
    output logic             clk_out,
    output logic             tick,
    output logic [DIV_W-1:0] active_div,
    output logic             update_done
`ifdef CLK_FREQ_DIV_STATUS_EN
    ,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    output logic [31:0]      readdata
`endif
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W:0]   cnt_nxt;
    logic [DIV_W-1:0] hi_len;
    logic             at_boundary;
    logic             div_ok;
    logic             div_changed;

    // cnt_nxt carries an extra bit so N = 2^DIV_W - 1 compares without wrap.
    assign cnt_nxt     = {1'b0, cnt} + {1'b0, ONE};
    assign hi_len      = active_div - (active_div >> 1);
    assign at_boundary = (cnt == (active_div - ONE));
    assign div_ok      = (div_value >= DIV_W'(MIN_DIV));
    assign div_changed = (div_value != active_div);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            active_div  <= '0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            update_done <= 1'b0;
        end else begin
            tick        <= 1'b0;
            update_done <= 1'b0;
            case (state)
                IDLE: begin
                    active_div  <= div_value;
                    update_done <= div_changed;
                    cnt         <= '0;
                    if (div_ok) begin
                        clk_out <= 1'b1;
                        tick    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        clk_out <= 1'b0;
                    end
                end
                RUN: begin
                    if (!at_boundary) begin
                        cnt     <= cnt_nxt[DIV_W-1:0];
                        clk_out <= (cnt_nxt < {1'b0, hi_len});
                    end else begin
                        // Boundary: the only point div_value is sampled while running.
                        active_div  <= div_value;
                        update_done <= div_changed;
                        cnt         <= '0;
                        if (div_ok) begin
                            clk_out <= 1'b1;
                            tick    <= 1'b1;
                        end else begin
                            clk_out <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

`ifdef CLK_FREQ_DIV_STATUS_EN
    clk_freq_div_status #(
        .DIV_W(DIV_W)
    ) u_status (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .active_div (active_div),
        .run        (state == RUN),
        .clk_out    (clk_out),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .readdata   (readdata)
    );
`endif

endmodule

// File: tb/tb_clk_freq_div_gen.sv
// Directed self-checking bench for clk_freq_div_gen; status-slave test runs
// only when CLK_FREQ_DIV_STATUS_EN is defined.
module tb_clk_freq_div_gen;

    localparam int DIV_W = 32;

    logic             clk;
    logic             reset_n;
    logic [DIV_W-1:0] div_value;
    logic             clk_out;
    logic             tick;
    logic [DIV_W-1:0] active_div;
    logic             update_done;
`ifdef CLK_FREQ_DIV_STATUS_EN
    logic [1:0]       address;
    logic             chipselect;
    logic             read;
    logic [31:0]      readdata;
`endif

    int checks;
    int failures;

    clk_freq_div_gen #(
        .DIV_W(DIV_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .div_value   (div_value),
        .clk_out     (clk_out),
        .tick        (tick),
        .active_div  (active_div),
        .update_done (update_done)
`ifdef CLK_FREQ_DIV_STATUS_EN
        ,
        .address     (address),
        .chipselect  (chipselect),
        .read        (read),
        .readdata    (readdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int exp_clk[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
        int exp_tck[8] = '{1, 0, 0, 0, 1, 0, 0, 0};
        int exp_upd[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
        reset_n   = 1'b0;
        div_value = 32'd4;
        #1;
        checks++;
        if ({clk_out, tick, update_done} !== 3'b000 || active_div !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: clk_out=%0b tick=%0b upd=%0b active=%0d expected all 0",
                     clk_out, tick, update_done, active_div);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if ({clk_out, tick, update_done} !== 3'b000 || active_div !== 32'd0) begin
            failures++;
            $display("FAIL reset_release_idle: clk_out=%0b tick=%0b upd=%0b active=%0d expected all 0",
                     clk_out, tick, update_done, active_div);
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++;
            if (clk_out !== 1'(exp_clk[i]) || tick !== 1'(exp_tck[i]) ||
                update_done !== 1'(exp_upd[i]) || active_div !== 32'd4) begin
                failures++;
                $display("FAIL div4_cycle%0d: clk_out=%0b tick=%0b upd=%0b active=%0d expected %0d %0d %0d 4",
                         i, clk_out, tick, update_done, active_div, exp_clk[i], exp_tck[i], exp_upd[i]);
            end
        end
    endtask

    // Entered with cnt=3 of N=4 showing.
    task automatic test_change_mid_period();
        int exp_clk[9] = '{0, 0, 1, 1, 1, 0, 0, 0, 1};
        int exp_tck[9] = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
        int exp_upd[9] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
        int exp_act[9] = '{4, 4, 6, 6, 6, 6, 6, 6, 6};
        cyc();
        cyc();
        div_value = 32'd6;
        for (int i = 0; i < 9; i++) begin
            cyc();
            checks++;
            if (clk_out !== 1'(exp_clk[i]) || tick !== 1'(exp_tck[i]) ||
                update_done !== 1'(exp_upd[i]) || active_div !== 32'(exp_act[i])) begin
                failures++;
                $display("FAIL div4to6_cycle%0d: clk_out=%0b tick=%0b upd=%0b active=%0d expected %0d %0d %0d %0d",
                         i, clk_out, tick, update_done, active_div,
                         exp_clk[i], exp_tck[i], exp_upd[i], exp_act[i]);
            end
        end
    endtask

    // Entered with cnt=0 of N=6 showing.
    task automatic test_div3_div2();
        int exp_clk[11] = '{1, 1, 0, 0, 0, 1, 1, 0, 1, 1, 0};
        int exp_tck[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
        int exp_upd[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        int exp_act[11] = '{6, 6, 6, 6, 6, 3, 3, 3, 3, 3, 3};
        int exp_clk2[4] = '{1, 0, 1, 0};
        int exp_tck2[4] = '{1, 0, 1, 0};
        int exp_upd2[4] = '{1, 0, 0, 0};
        div_value = 32'd3;
        for (int i = 0; i < 11; i++) begin
            cyc();
            checks++;
            if (clk_out !== 1'(exp_clk[i]) || tick !== 1'(exp_tck[i]) ||
                update_done !== 1'(exp_upd[i]) || active_div !== 32'(exp_act[i])) begin
                failures++;
                $display("FAIL div3_cycle%0d: clk_out=%0b tick=%0b upd=%0b active=%0d expected %0d %0d %0d %0d",
                         i, clk_out, tick, update_done, active_div,
                         exp_clk[i], exp_tck[i], exp_upd[i], exp_act[i]);
            end
        end
        div_value = 32'd2;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (clk_out !== 1'(exp_clk2[i]) || tick !== 1'(exp_tck2[i]) ||
                update_done !== 1'(exp_upd2[i]) || active_div !== 32'd2) begin
                failures++;
                $display("FAIL div2_cycle%0d: clk_out=%0b tick=%0b upd=%0b active=%0d expected %0d %0d %0d 2",
                         i, clk_out, tick, update_done, active_div, exp_clk2[i], exp_tck2[i], exp_upd2[i]);
            end
        end
    endtask

    // Entered with cnt=1 of N=2 showing.
    task automatic test_to_idle();
        int exp_clk[7] = '{1, 1, 0, 0, 0, 0, 0};
        int exp_upd[7] = '{0, 0, 0, 0, 1, 0, 0};
        int exp_act[7] = '{5, 5, 5, 5, 0, 0, 0};
        int exp_upd1[2] = '{1, 0};
        div_value = 32'd5;
        cyc();
        checks++;
        if (clk_out !== 1'b1 || tick !== 1'b1 || update_done !== 1'b1 || active_div !== 32'd5) begin
            failures++;
            $display("FAIL div5_start: clk_out=%0b tick=%0b upd=%0b active=%0d expected 1 1 1 5",
                     clk_out, tick, update_done, active_div);
        end
        div_value = 32'd0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            checks++;
            if (clk_out !== 1'(exp_clk[i]) || tick !== 1'b0 ||
                update_done !== 1'(exp_upd[i]) || active_div !== 32'(exp_act[i])) begin
                failures++;
                $display("FAIL to_idle_cycle%0d: clk_out=%0b tick=%0b upd=%0b active=%0d expected %0d 0 %0d %0d",
                         i, clk_out, tick, update_done, active_div, exp_clk[i], exp_upd[i], exp_act[i]);
            end
        end
        div_value = 32'd1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (clk_out !== 1'b0 || tick !== 1'b0 ||
                update_done !== 1'(exp_upd1[i]) || active_div !== 32'd1) begin
                failures++;
                $display("FAIL idle_div1_cycle%0d: clk_out=%0b tick=%0b upd=%0b active=%0d expected 0 0 %0d 1",
                         i, clk_out, tick, update_done, active_div, exp_upd1[i]);
            end
        end
    endtask

    // Entered in IDLE with active_div=1.
    task automatic test_reset_mid_period();
        int exp_clk[9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
        int exp_tck[9] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
        int exp_upd[9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        div_value = 32'd8;
        repeat (3) cyc();
        checks++;
        if (clk_out !== 1'b1 || active_div !== 32'd8) begin
            failures++;
            $display("FAIL div8_cnt2: clk_out=%0b active=%0d expected 1 8", clk_out, active_div);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({clk_out, tick, update_done} !== 3'b000 || active_div !== 32'd0) begin
            failures++;
            $display("FAIL async_reset: clk_out=%0b tick=%0b upd=%0b active=%0d expected all 0",
                     clk_out, tick, update_done, active_div);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            checks++;
            if (clk_out !== 1'(exp_clk[i]) || tick !== 1'(exp_tck[i]) ||
                update_done !== 1'(exp_upd[i]) || active_div !== 32'd8) begin
                failures++;
                $display("FAIL restart8_cycle%0d: clk_out=%0b tick=%0b upd=%0b active=%0d expected %0d %0d %0d 8",
                         i, clk_out, tick, update_done, active_div, exp_clk[i], exp_tck[i], exp_upd[i]);
            end
        end
    endtask

`ifdef CLK_FREQ_DIV_STATUS_EN
    task automatic test_status();
        logic [1:0]  addr_seq[4] = '{2'd1, 2'd0, 2'd2, 2'd3};
        logic [31:0] exp_rd[4]   = '{32'd3, 32'd4, 32'd3, 32'd0};
        reset_n    = 1'b0;
        div_value  = 32'd4;
        chipselect = 1'b0;
        read       = 1'b0;
        address    = 2'd0;
        #1;
        checks++;
        if (readdata !== 32'd0) begin
            failures++;
            $display("FAIL status_reset: readdata=%0d expected 0", readdata);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) cyc();
        // Three full periods elapsed; counter holds 3 until the next tick is counted.
        chipselect = 1'b1;
        read       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            address = addr_seq[i];
            cyc();
            checks++;
            if (readdata !== exp_rd[i]) begin
                failures++;
                $display("FAIL status_addr%0d: readdata=0x%08h expected 0x%08h",
                         addr_seq[i], readdata, exp_rd[i]);
            end
        end
        read = 1'b0;
        address = 2'd1;
        cyc();
        checks++;
        if (readdata !== 32'd0) begin
            failures++;
            $display("FAIL status_idle_bus: readdata=0x%08h expected 0", readdata);
        end
        chipselect = 1'b0;
    endtask
`endif

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        div_value = '0;
`ifdef CLK_FREQ_DIV_STATUS_EN
        address    = 2'd0;
        chipselect = 1'b0;
        read       = 1'b0;
`endif
        test_reset();
        test_change_mid_period();
        test_div3_div2();
        test_to_idle();
        test_reset_mid_period();
`ifdef CLK_FREQ_DIV_STATUS_EN
        test_status();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
